matrix_stream_loader: RTL and testbench

//  Front-end fetch stage that sits between the M10K read port and the compute datapath.
//  On start, it reads a one-word operation header at a base address and decodes the opcode
//  and both operand shapes. It then streams operand A and then operand B element words to the

---
 rtl/matrix_stream_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// Header-driven operand fetch: reads an op header, then streams operand A and B words
// from memory through a 2-entry tagged FIFO onto a valid/ready channel.
module matrix_stream_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [3:0]            opcode,
  output logic [6:0]            a_rows,
  output logic [6:0]            a_cols,
  output logic [6:0]            b_rows,
  output logic [6:0]            b_cols,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sel,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_REQ  = 3'd1,
    ST_HDR_WAIT = 3'd2,
    ST_FETCH    = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [13:0]             na_r;
  logic [13:0]             nb_r;
  logic [14:0]             issue_cnt_r;
  logic                    pend_r;
  logic                    tag_sel_r;
  logic                    tag_last_r;
  logic [1:0]              fifo_count_r;
  logic [DATA_WIDTH-1:0]   tail_data_r;
  logic                    tail_sel_r;
  logic                    tail_last_r;

  logic [6:0]              hdr_ar_s;
  logic [6:0]              hdr_ac_s;
  logic [6:0]              hdr_br_s;
  logic [6:0]              hdr_bc_s;
  logic                    hdr_zero_s;
  logic [13:0]             hdr_na_s;
  logic [13:0]             hdr_nb_s;
  logic [14:0]             total_s;
  logic                    push_s;
  logic                    pop_s;
  logic [1:0]              count_after_s;
  logic                    fetch_done_s;
  logic                    can_issue_s;
  logic                    issue_sel_s;
  logic                    issue_last_s;
  logic [ADDR_WIDTH-1:0]   issue_addr_s;

  // A word closes its operand when it is the final A element or the final B element
  function automatic logic is_last_word(input logic [14:0] idx, input logic [13:0] na,
                                        input logic [13:0] nb);
    logic [14:0] na_w;
    logic [14:0] tot_w;
    na_w  = {1'b0, na};
    tot_w = na_w + {1'b0, nb};
    return (idx == na_w - 15'd1) || (idx == tot_w - 15'd1);
  endfunction

  // Header decode, FIFO occupancy forecast and read-issue decision
  always_comb begin
    hdr_ar_s     = mem_readdata[27:21];
    hdr_ac_s     = mem_readdata[20:14];
    hdr_br_s     = mem_readdata[13:7];
    hdr_bc_s     = mem_readdata[6:0];
    hdr_zero_s   = (hdr_ar_s == 7'd0) || (hdr_ac_s == 7'd0) ||
                   (hdr_br_s == 7'd0) || (hdr_bc_s == 7'd0);
    hdr_na_s     = {7'd0, hdr_ar_s} * {7'd0, hdr_ac_s};
    hdr_nb_s     = {7'd0, hdr_br_s} * {7'd0, hdr_bc_s};
    total_s      = {1'b0, na_r} + {1'b0, nb_r};
    push_s       = pend_r;
    pop_s        = out_valid & out_ready;
    case ({push_s, pop_s})
      2'b10:   count_after_s = fifo_count_r + 2'd1;
      2'b01:   count_after_s = fifo_count_r - 2'd1;
      default: count_after_s = fifo_count_r;
    endcase
    fetch_done_s = (issue_cnt_r == total_s);
    // One read outstanding at most; the next goes out only once its slot is guaranteed
    if ((state_r == ST_FETCH) && !fetch_done_s && !mem_read && (count_after_s < 2'd2)) begin
      can_issue_s = 1'b1;
    end else begin
      can_issue_s = 1'b0;
    end
    issue_sel_s  = (issue_cnt_r >= {1'b0, na_r});
    issue_last_s = is_last_word(issue_cnt_r, na_r, nb_r);
    issue_addr_s = base_r + ADDR_WIDTH'(issue_cnt_r + 15'd1);
  end

  // Load sequencer: header fetch, element read issue, drain and completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      base_r      <= '0;
      na_r        <= 14'd0;
      nb_r        <= 14'd0;
      issue_cnt_r <= 15'd0;
      pend_r      <= 1'b0;
      tag_sel_r   <= 1'b0;
      tag_last_r  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      opcode      <= 4'd0;
      a_rows      <= 7'd0;
      a_cols      <= 7'd0;
      b_rows      <= 7'd0;
      b_cols      <= 7'd0;
      mem_read    <= 1'b0;
      mem_address <= '0;
    end else begin
      pend_r <= mem_read && (state_r == ST_FETCH);
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_r      <= base_addr;
            error       <= 1'b0;
            busy        <= 1'b1;
            mem_read    <= 1'b1;
            mem_address <= base_addr;
            issue_cnt_r <= 15'd0;
            state_r     <= ST_HDR_REQ;
          end
        end
        ST_HDR_REQ: begin
          mem_read <= 1'b0;
          state_r  <= ST_HDR_WAIT;
        end
        ST_HDR_WAIT: begin
          opcode <= mem_readdata[31:28];
          a_rows <= hdr_ar_s;
          a_cols <= hdr_ac_s;
          b_rows <= hdr_br_s;
          b_cols <= hdr_bc_s;
          na_r   <= hdr_na_s;
          nb_r   <= hdr_nb_s;
          if (hdr_zero_s) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_done_s) begin
            mem_read <= 1'b0;
            state_r  <= ST_DRAIN;
          end else if (can_issue_s) begin
            mem_read    <= 1'b1;
            mem_address <= issue_addr_s;
            tag_sel_r   <= issue_sel_s;
            tag_last_r  <= issue_last_s;
            issue_cnt_r <= issue_cnt_r + 15'd1;
          end else begin
            mem_read <= 1'b0;
          end
        end
        ST_DRAIN: begin
          mem_read <= 1'b0;
          if ((fifo_count_r == 2'd0) && !pend_r) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          mem_read <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-entry FIFO; the head lives directly in the out_* registers so it holds under stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_count_r <= 2'd0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sel      <= 1'b0;
      out_last     <= 1'b0;
      tail_data_r  <= '0;
      tail_sel_r   <= 1'b0;
      tail_last_r  <= 1'b0;
    end else begin
      fifo_count_r <= count_after_s;
      out_valid    <= (count_after_s != 2'd0);
      case ({push_s, pop_s})
        2'b10: begin
          if (fifo_count_r == 2'd0) begin
            out_data <= mem_readdata;
            out_sel  <= tag_sel_r;
            out_last <= tag_last_r;
          end else begin
            tail_data_r <= mem_readdata;
            tail_sel_r  <= tag_sel_r;
            tail_last_r <= tag_last_r;
          end
        end
        2'b01: begin
          out_data <= tail_data_r;
          out_sel  <= tail_sel_r;
          out_last <= tail_last_r;
        end
        2'b11: begin
          if (fifo_count_r == 2'd1) begin
            out_data <= mem_readdata;
            out_sel  <= tag_sel_r;
            out_last <= tag_last_r;
          end else begin
            out_data    <= tail_data_r;
            out_sel     <= tail_sel_r;
            out_last    <= tail_last_r;
            tail_data_r <= mem_readdata;
            tail_sel_r  <= tag_sel_r;
            tail_last_r <= tag_last_r;
          end
        end
        default: begin
          out_data <= out_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: memory model, operand-order reference model, scenario tasks.
module tb_matrix_stream_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        busy, done, error;
  logic [3:0]  opcode;
  logic [6:0]  a_rows, a_cols, b_rows, b_cols;
  logic        mem_read;
  logic [7:0]  mem_address;
  logic [31:0] mem_readdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_sel, out_last;

  matrix_stream_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .error(error), .opcode(opcode),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .mem_read(mem_read), .mem_address(mem_address), .mem_readdata(mem_readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: data for a read appears the cycle after the strobe
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  always @(posedge clock) if (mem_read) rd_q <= mem[mem_address];
  assign mem_readdata = rd_q;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_data[$];
  bit          exp_sel[$];
  bit          exp_last[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] obs_data[$];
  bit          obs_sel[$];
  bit          obs_last[$];
  logic [7:0]  obs_addr[$];
  int  done_cnt, done_cycle, last_acc, valid_cycles, thr_viol, stab_viol;
  logic err_at_done, busy_first, busy_end, err_end;
  bit  timed_out;

  // Reference: header at base, then A row-major, then B, at consecutive wrapping addresses
  task automatic build_model(input logic [7:0] base, input logic [31:0] hdr);
    int na, nb;
    logic [7:0] a;
    exp_data.delete(); exp_sel.delete(); exp_last.delete(); exp_addr.delete();
    exp_addr.push_back(base);
    na = int'(hdr[27:21]) * int'(hdr[20:14]);
    nb = int'(hdr[13:7]) * int'(hdr[6:0]);
    if (na == 0 || nb == 0) return;
    for (int k = 0; k < na + nb; k++) begin
      a = base + 8'(k + 1);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
      exp_sel.push_back(k >= na);
      exp_last.push_back((k < na) ? (k == na - 1) : (k - na == nb - 1));
    end
  endtask

  function automatic int seq_errors(output int first);
    int n;
    n = 0; first = -1;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++)
      if (obs_data[i] !== exp_data[i] || obs_sel[i] !== exp_sel[i] || obs_last[i] !== exp_last[i]) begin
        if (first < 0) first = i;
        n++;
      end
    return n;
  endfunction

  function automatic int addr_errors();
    int n;
    n = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i]) n++;
    return n;
  endfunction

  // Runs one load from the current negedge and records what the DUT produced
  task automatic run_load(input logic [7:0] base, input int mode, input int start_at,
                          input logic [7:0] alt_base);
    int cyc, accepted;
    bit hold;
    logic [31:0] held;
    obs_data.delete(); obs_sel.delete(); obs_last.delete(); obs_addr.delete();
    done_cnt = 0; done_cycle = 0; last_acc = 0; valid_cycles = 0;
    thr_viol = 0; stab_viol = 0; timed_out = 0; err_at_done = 1'b0;
    accepted = 0; hold = 0; held = 32'd0; cyc = 0;
    base_addr = base;
    start = 1'b1;
    while (1) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 1) busy_first = busy;
      if (mem_read) begin
        obs_addr.push_back(mem_address);
        if (obs_addr.size() > 1 && (obs_addr.size() - 2 - accepted) > 1) thr_viol++;
      end
      if (hold && (!out_valid || out_data !== held)) stab_viol++;
      hold = out_valid && !out_ready;
      held = out_data;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_sel.push_back(out_sel);
        obs_last.push_back(out_last);
        accepted++;
        last_acc = cyc;
        if (accepted == start_at) begin
          start = 1'b1;
          base_addr = alt_base;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cycle = cyc;
          err_at_done = error;
        end
      end
      if (done_cnt > 0 && cyc >= done_cycle + 3) break;
      if (cyc >= 2000) begin
        timed_out = 1;
        break;
      end
    end
    busy_end = busy;
    err_end = error;
    out_ready = 1'b0;
  endtask

  task automatic fill_test1_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0] = {4'd1, 7'd2, 7'd3, 7'd3, 7'd2};
    for (int i = 1; i <= 6; i++) mem[i] = 32'(i);
    for (int i = 7; i <= 12; i++) mem[i] = 32'(i + 3);
    mem[8'h40] = {4'd3, 7'd1, 7'd1, 7'd1, 7'd1};
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, error, mem_read, out_valid, out_sel, out_last} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, error, mem_read, out_valid, out_sel, out_last});
    end
    checks++;
    if ({opcode, a_rows, a_cols, b_rows, b_cols} !== 32'd0) begin
      failures++;
      $display("FAIL reset_hdr: got %h want 0", {opcode, a_rows, a_cols, b_rows, b_cols});
    end
    checks++;
    if (out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
  endtask

  task automatic test_basic();
    int first, n;
    fill_test1_mem();
    build_model(8'd0, mem[0]);
    run_load(8'd0, 0, -1, 8'd0);
    checks++;
    if (busy_first !== 1'b1) begin failures++; $display("FAIL t1_busy: got %b want 1", busy_first); end
    checks++;
    if (obs_data.size() !== 12) begin failures++; $display("FAIL t1_count: got %0d want 12", obs_data.size()); end
    n = seq_errors(first);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL t1_seq: %0d bad words, first at %0d got %h/%b/%b want %h/%b/%b", n, first,
               obs_data[first], obs_sel[first], obs_last[first], exp_data[first], exp_sel[first], exp_last[first]);
    end
    checks++;
    if (obs_addr.size() !== 13 || addr_errors() !== 0) begin
      failures++; $display("FAIL t1_addr: got %0d reads, %0d wrong want 13, 0", obs_addr.size(), addr_errors());
    end
    checks++;
    if (done_cnt !== 1 || err_at_done !== 1'b0 || timed_out) begin
      failures++; $display("FAIL t1_done: got done=%0d err=%b timeout=%0d want 1 0 0", done_cnt, err_at_done, timed_out);
    end
    checks++;
    if (done_cycle - last_acc !== 2) begin
      failures++; $display("FAIL t1_done_lat: got %0d want 2", done_cycle - last_acc);
    end
    checks++;
    if ({opcode, a_rows, a_cols, b_rows, b_cols} !== mem[0]) begin
      failures++; $display("FAIL t1_hdr: got %h want %h", {opcode, a_rows, a_cols, b_rows, b_cols}, mem[0]);
    end
    checks++;
    if (valid_cycles !== 12 || busy_end !== 1'b0) begin
      failures++; $display("FAIL t1_valid: got valid=%0d busy=%b want 12 0", valid_cycles, busy_end);
    end
  endtask

  task automatic test_backpressure();
    int first, n;
    fill_test1_mem();
    build_model(8'd0, mem[0]);
    run_load(8'd0, 1, -1, 8'd0);
    checks++;
    if (obs_data.size() !== 12) begin failures++; $display("FAIL t2_count: got %0d want 12", obs_data.size()); end
    n = seq_errors(first);
    checks++;
    if (n !== 0) begin failures++; $display("FAIL t2_seq: got %0d bad words (first %0d) want 0", n, first); end
    checks++;
    if (thr_viol !== 0) begin failures++; $display("FAIL t2_throttle: got %0d violations want 0", thr_viol); end
    checks++;
    if (stab_viol !== 0) begin failures++; $display("FAIL t2_stable: got %0d violations want 0", stab_viol); end
    checks++;
    if (obs_addr.size() !== 13 || addr_errors() !== 0 || done_cnt !== 1) begin
      failures++; $display("FAIL t2_addr: got reads=%0d bad=%0d done=%0d want 13 0 1", obs_addr.size(), addr_errors(), done_cnt);
    end
  endtask

  task automatic test_zero_dim();
    fill_test1_mem();
    mem[0] = {4'd2, 7'd0, 7'd3, 7'd3, 7'd2};
    run_load(8'd0, 0, -1, 8'd0);
    checks++;
    if (err_at_done !== 1'b1 || done_cnt !== 1) begin
      failures++; $display("FAIL t3_error: got err=%b done=%0d want 1 1", err_at_done, done_cnt);
    end
    checks++;
    if (valid_cycles !== 0) begin failures++; $display("FAIL t3_valid: got %0d want 0", valid_cycles); end
    checks++;
    if (obs_addr.size() !== 1) begin failures++; $display("FAIL t3_reads: got %0d want 1", obs_addr.size()); end
    checks++;
    if (err_end !== 1'b1) begin failures++; $display("FAIL t3_sticky: got %b want 1", err_end); end
  endtask

  task automatic test_wrap();
    int first, n;
    mem[8'hFD] = {4'd5, 7'd1, 7'd1, 7'd1, 7'd2};
    mem[8'hFE] = 32'h3F80_0000;
    mem[8'hFF] = 32'h4000_0000;
    mem[8'h00] = 32'h4040_0000;
    build_model(8'hFD, mem[8'hFD]);
    run_load(8'hFD, 0, -1, 8'd0);
    checks++;
    if (obs_addr.size() !== 4 || addr_errors() !== 0) begin
      failures++; $display("FAIL t4_addr: got reads=%0d bad=%0d want 4 0", obs_addr.size(), addr_errors());
    end
    n = seq_errors(first);
    checks++;
    if (obs_data.size() !== 3 || n !== 0) begin
      failures++; $display("FAIL t4_seq: got words=%0d bad=%0d want 3 0", obs_data.size(), n);
    end
    checks++;
    if (err_at_done !== 1'b0) begin failures++; $display("FAIL t4_error: got %b want 0", err_at_done); end
  endtask

  task automatic test_start_while_busy();
    int first, n;
    fill_test1_mem();
    build_model(8'd0, mem[0]);
    run_load(8'd0, 0, 4, 8'h40);
    n = seq_errors(first);
    checks++;
    if (obs_data.size() !== 12 || n !== 0) begin
      failures++; $display("FAIL t5_seq: got words=%0d bad=%0d want 12 0", obs_data.size(), n);
    end
    checks++;
    if (obs_addr.size() !== 13 || addr_errors() !== 0 || done_cnt !== 1 || busy_end !== 1'b0) begin
      failures++; $display("FAIL t5_ignored: got reads=%0d bad=%0d done=%0d busy=%b want 13 0 1 0",
                           obs_addr.size(), addr_errors(), done_cnt, busy_end);
    end
  endtask

  task automatic test_reset_mid();
    int first, n;
    bit found;
    fill_test1_mem();
    build_model(8'd0, mem[0]);
    base_addr = 8'd0;
    out_ready = 1'b1;
    start = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (mem_read && mem_address == 8'd3) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL t6_reach: got no read at 3 want one"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, mem_read, out_valid, out_sel, out_last, out_data, opcode} !== 43'd0) begin
      failures++; $display("FAIL t6_reset_out: got %h want 0",
                           {busy, done, error, mem_read, out_valid, out_sel, out_last, out_data, opcode});
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_load(8'd0, 0, -1, 8'd0);
    n = seq_errors(first);
    checks++;
    if (obs_data.size() !== 12 || n !== 0 || done_cnt !== 1) begin
      failures++; $display("FAIL t6_reload: got words=%0d bad=%0d done=%0d want 12 0 1", obs_data.size(), n, done_cnt);
    end
  endtask

  task automatic test_random();
    int first, n;
    logic [7:0] base;
    logic [31:0] hdr;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      base = 8'($urandom_range(0, 255));
      hdr = {4'($urandom_range(0, 15)), 7'($urandom_range(1, 4)), 7'($urandom_range(1, 4)),
             7'($urandom_range(1, 4)), 7'($urandom_range(1, 4))};
      mem[base] = hdr;
      build_model(base, hdr);
      run_load(base, 2, -1, 8'd0);
      n = seq_errors(first);
      checks++;
      if (obs_data.size() !== exp_data.size() || n !== 0) begin
        failures++; $display("FAIL rnd%0d_seq: got words=%0d bad=%0d want %0d 0", it, obs_data.size(), n, exp_data.size());
      end
      checks++;
      if (obs_addr.size() !== exp_addr.size() || addr_errors() !== 0) begin
        failures++; $display("FAIL rnd%0d_addr: got reads=%0d bad=%0d want %0d 0", it, obs_addr.size(), addr_errors(), exp_addr.size());
      end
      checks++;
      if (thr_viol !== 0 || stab_viol !== 0 || done_cnt !== 1 || err_at_done !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_proto: got thr=%0d stab=%0d done=%0d err=%b want 0 0 1 0",
                             it, thr_viol, stab_viol, done_cnt, err_at_done);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
